sp_ram_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the 1024x16 single-port block RAM used as the OFDM sample/symbol buffer. It lets two clients (e.g. the sample writer and the FFT/demapper reader) share the one RAM port. Each client sees a simple request/grant interface with tagged read-data return. Arbitration is round-robin, with an optional lock that holds ownership across a burst.

---
 rtl/sp_ram_arbiter.sv | 139 +++++++++++++
 tb/tb_sp_ram_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter that shares one 1024x16 single-port block RAM between two
// request/grant clients, with optional burst lock and per-port tagged read return.
module sp_ram_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_p0,
  input  logic              req_p1,
  input  logic              we_p0,
  input  logic              we_p1,
  input  logic              lock_p0,
  input  logic              lock_p1,
  input  logic [ADDR_W-1:0] addr_p0,
  input  logic [ADDR_W-1:0] addr_p1,
  input  logic [DATA_W-1:0] wdata_p0,
  input  logic [DATA_W-1:0] wdata_p1,
  output logic              gnt_p0,
  output logic              gnt_p1,
  output logic              rvalid_p0,
  output logic              rvalid_p1,
  output logic [DATA_W-1:0] rdata_p0,
  output logic [DATA_W-1:0] rdata_p1,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_wre,
  output logic              ram_reset,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  owner_e            owner_q, owner_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              rd_tag_vld_q, rd_tag_vld_d;
  logic              rd_tag_port_q, rd_tag_port_d;
  logic              rvalid_p0_q, rvalid_p0_d;
  logic              rvalid_p1_q, rvalid_p1_d;
  logic [DATA_W-1:0] rdata_p0_q, rdata_p0_d;
  logic [DATA_W-1:0] rdata_p1_q, rdata_p1_d;

  // An owner excludes the other port entirely; otherwise rr_ptr breaks ties.
  always_comb begin
    gnt_p0 = 1'b0;
    gnt_p1 = 1'b0;
    case (owner_q)
      OWN_P0: gnt_p0 = req_p0;
      OWN_P1: gnt_p1 = req_p1;
      default: begin
        if (req_p0 && req_p1) begin
          gnt_p0 = ~rr_ptr_q;
          gnt_p1 = rr_ptr_q;
        end else begin
          gnt_p0 = req_p0;
          gnt_p1 = req_p1;
        end
      end
    endcase
  end

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    rd_tag_vld_d  = 1'b0;
    rd_tag_port_d = rd_tag_port_q;
    rvalid_p0_d   = 1'b0;
    rvalid_p1_d   = 1'b0;
    rdata_p0_d    = rdata_p0_q;
    rdata_p1_d    = rdata_p1_q;

    if (gnt_p0) begin
      rr_ptr_d      = 1'b1;
      owner_d       = lock_p0 ? OWN_P0 : OWN_NONE;
      rd_tag_vld_d  = ~we_p0;
      rd_tag_port_d = 1'b0;
    end else if (gnt_p1) begin
      rr_ptr_d      = 1'b0;
      owner_d       = lock_p1 ? OWN_P1 : OWN_NONE;
      rd_tag_vld_d  = ~we_p1;
      rd_tag_port_d = 1'b1;
    end else if ((owner_q == OWN_P0 && !lock_p0) || (owner_q == OWN_P1 && !lock_p1)) begin
      owner_d = OWN_NONE;
    end

    // RAM is in bypass mode, so ram_dout belongs to the read issued last edge.
    if (rd_tag_vld_q) begin
      if (rd_tag_port_q) begin
        rdata_p1_d  = ram_dout;
        rvalid_p1_d = 1'b1;
      end else begin
        rdata_p0_d  = ram_dout;
        rvalid_p0_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q       <= OWN_NONE;
      rr_ptr_q      <= 1'b0;
      rd_tag_vld_q  <= 1'b0;
      rd_tag_port_q <= 1'b0;
      rvalid_p0_q   <= 1'b0;
      rvalid_p1_q   <= 1'b0;
      rdata_p0_q    <= '0;
      rdata_p1_q    <= '0;
    end else begin
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      rd_tag_vld_q  <= rd_tag_vld_d;
      rd_tag_port_q <= rd_tag_port_d;
      rvalid_p0_q   <= rvalid_p0_d;
      rvalid_p1_q   <= rvalid_p1_d;
      rdata_p0_q    <= rdata_p0_d;
      rdata_p1_q    <= rdata_p1_d;
    end
  end

  assign rvalid_p0 = rvalid_p0_q;
  assign rvalid_p1 = rvalid_p1_q;
  assign rdata_p0  = rdata_p0_q;
  assign rdata_p1  = rdata_p1_q;

  // With no grant the address/data mux idles on the p0 fields.
  assign ram_ce    = gnt_p0 | gnt_p1;
  assign ram_oce   = 1'b1;
  assign ram_wre   = gnt_p1 ? we_p1 : (gnt_p0 & we_p0);
  assign ram_reset = ~rst_n;
  assign ram_ad    = gnt_p1 ? addr_p1 : addr_p0;
  assign ram_din   = gnt_p1 ? wdata_p1 : wdata_p0;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Self-checking bench for sp_ram_arbiter: behavioural RAM plus a transaction-level
// reference model of arbitration, memory contents and read returns.
module tb_sp_ram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req_p0, req_p1, we_p0, we_p1, lock_p0, lock_p1;
  logic [9:0]  addr_p0, addr_p1;
  logic [15:0] wdata_p0, wdata_p1;
  logic        gnt_p0, gnt_p1, rvalid_p0, rvalid_p1;
  logic [15:0] rdata_p0, rdata_p1;
  logic        ram_ce, ram_oce, ram_wre, ram_reset;
  logic [9:0]  ram_ad;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;

  int errors = 0;
  int checks = 0;

  sp_ram_arbiter #(.ADDR_W(10), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_p0(req_p0), .req_p1(req_p1), .we_p0(we_p0), .we_p1(we_p1),
    .lock_p0(lock_p0), .lock_p1(lock_p1),
    .addr_p0(addr_p0), .addr_p1(addr_p1),
    .wdata_p0(wdata_p0), .wdata_p1(wdata_p1),
    .gnt_p0(gnt_p0), .gnt_p1(gnt_p1),
    .rvalid_p0(rvalid_p0), .rvalid_p1(rvalid_p1),
    .rdata_p0(rdata_p0), .rdata_p1(rdata_p1),
    .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre), .ram_reset(ram_reset),
    .ram_ad(ram_ad), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM, bypass read mode.
  logic [15:0] ram_mem [1024];
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_wre) ram_mem[ram_ad] <= ram_din;
      else         ram_dout <= ram_mem[ram_ad];
    end
  end

  // Reference model: -1 means "no port".
  int          m_rr, m_owner, m_ret_port;
  logic [15:0] m_ret_data;
  logic [15:0] m_mem [1024];
  logic        m_rvalid [2];
  logic [15:0] m_rdata [2];

  function automatic void model_reset();
    m_rr = 0; m_owner = -1; m_ret_port = -1;
    m_rvalid[0] = 1'b0; m_rvalid[1] = 1'b0;
    m_rdata[0] = 16'h0; m_rdata[1] = 16'h0;
  endfunction

  function automatic int exp_grant();
    if (m_owner == 0) return req_p0 ? 0 : -1;
    if (m_owner == 1) return req_p1 ? 1 : -1;
    if (req_p0 && req_p1) return m_rr;
    if (req_p0) return 0;
    if (req_p1) return 1;
    return -1;
  endfunction

  task automatic idle_inputs();
    req_p0 = 0; req_p1 = 0; we_p0 = 0; we_p1 = 0; lock_p0 = 0; lock_p1 = 0;
    addr_p0 = '0; addr_p1 = '0; wdata_p0 = '0; wdata_p1 = '0;
  endtask

  // Advance one clock edge and apply the same edge to the reference model.
  task automatic tick();
    int          g;
    logic        w, l;
    logic [9:0]  a;
    logic [15:0] d;
    g = exp_grant();
    @(posedge clk);
    if (rst_n) begin
      m_rvalid[0] = 1'b0; m_rvalid[1] = 1'b0;
      if (m_ret_port >= 0) begin
        m_rvalid[m_ret_port] = 1'b1;
        m_rdata[m_ret_port]  = m_ret_data;
      end
      m_ret_port = -1;
      if (g >= 0) begin
        w = (g == 1) ? we_p1 : we_p0;
        l = (g == 1) ? lock_p1 : lock_p0;
        a = (g == 1) ? addr_p1 : addr_p0;
        d = (g == 1) ? wdata_p1 : wdata_p0;
        if (w) m_mem[a] = d;
        else begin m_ret_port = g; m_ret_data = m_mem[a]; end
        m_rr = 1 - g;
        m_owner = l ? g : -1;
      end else if (m_owner >= 0) begin
        if (!((m_owner == 1) ? lock_p1 : lock_p0)) m_owner = -1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0;
    idle_inputs();
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++; if (rvalid_p0 !== 1'b0 || rvalid_p1 !== 1'b0) begin errors++;
      $display("[TB] FAIL reset_rvalid: got %b%b expected 00", rvalid_p1, rvalid_p0); end
    checks++; if (rdata_p0 !== 16'h0 || rdata_p1 !== 16'h0) begin errors++;
      $display("[TB] FAIL reset_rdata: got %h/%h expected 0000/0000", rdata_p0, rdata_p1); end
    checks++; if (ram_reset !== 1'b1 || ram_oce !== 1'b1 || ram_ce !== 1'b0) begin errors++;
      $display("[TB] FAIL reset_ram_ctl: got reset=%b oce=%b ce=%b expected 1 1 0", ram_reset, ram_oce, ram_ce); end
    req_p0 = 1; req_p1 = 1; #1;
    checks++; if (gnt_p0 !== 1'b1 || gnt_p1 !== 1'b0) begin errors++;
      $display("[TB] FAIL reset_gnt_rr0: got %b%b expected p0 granted", gnt_p1, gnt_p0); end
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1; #1;
    checks++; if (ram_reset !== 1'b0) begin errors++;
      $display("[TB] FAIL ram_reset_release: got %b expected 0", ram_reset); end
  endtask

  task automatic test_write_read();
    req_p0 = 1; we_p0 = 1; addr_p0 = 10'h003; wdata_p0 = 16'hA5A5; #1;
    checks++; if (gnt_p0 !== 1'b1 || ram_ce !== 1'b1 || ram_wre !== 1'b1 || ram_ad !== 10'h003 || ram_din !== 16'hA5A5) begin errors++;
      $display("[TB] FAIL wr_grant: got gnt=%b ce=%b wre=%b ad=%h din=%h expected 1 1 1 003 a5a5", gnt_p0, ram_ce, ram_wre, ram_ad, ram_din); end
    tick();
    we_p0 = 0; #1;
    checks++; if (gnt_p0 !== 1'b1 || ram_wre !== 1'b0) begin errors++;
      $display("[TB] FAIL rd_grant: got gnt=%b wre=%b expected 1 0", gnt_p0, ram_wre); end
    tick();
    idle_inputs(); #1;
    checks++; if (rvalid_p0 !== 1'b0) begin errors++;
      $display("[TB] FAIL rd_early: got rvalid_p0=%b expected 0", rvalid_p0); end
    tick();
    checks++; if (rvalid_p0 !== 1'b1 || rdata_p0 !== 16'hA5A5 || rvalid_p1 !== 1'b0) begin errors++;
      $display("[TB] FAIL rd_return: got v0=%b d0=%h v1=%b expected 1 a5a5 0", rvalid_p0, rdata_p0, rvalid_p1); end
    tick();
    checks++; if (rvalid_p0 !== 1'b0 || rdata_p0 !== 16'hA5A5) begin errors++;
      $display("[TB] FAIL rd_pulse_hold: got v0=%b d0=%h expected 0 a5a5", rvalid_p0, rdata_p0); end
  endtask

  task automatic test_alternating();
    do_reset();
    for (int i = 0; i < 14; i++) begin
      if (i < 12) begin
        req_p0 = 1; req_p1 = 1; we_p0 = 0; we_p1 = 0;
        addr_p0 = 10'($urandom); addr_p1 = 10'($urandom);
      end else idle_inputs();
      #1;
      if (i < 12) begin
        checks++; if (gnt_p0 !== (i % 2 == 0) || gnt_p1 !== (i % 2 == 1)) begin errors++;
          $display("[TB] FAIL alt_gnt[%0d]: got %b%b expected p%0d", i, gnt_p1, gnt_p0, i % 2); end
      end
      checks++; if (rvalid_p0 !== (i >= 2 && i % 2 == 0) || rvalid_p1 !== (i >= 2 && i % 2 == 1)) begin errors++;
        $display("[TB] FAIL alt_rvalid[%0d]: got %b%b", i, rvalid_p1, rvalid_p0); end
      checks++; if (rdata_p0 !== m_rdata[0] || rdata_p1 !== m_rdata[1]) begin errors++;
        $display("[TB] FAIL alt_rdata[%0d]: got %h/%h expected %h/%h", i, rdata_p0, rdata_p1, m_rdata[0], m_rdata[1]); end
      tick();
    end
  endtask

  task automatic test_lock();
    for (int i = 0; i < 9; i++) begin
      req_p0 = (i >= 1); we_p0 = 0; addr_p0 = 10'($urandom);
      req_p1 = (i < 4); we_p1 = 0; lock_p1 = (i < 7); addr_p1 = 10'($urandom);
      #1;
      checks++; if (gnt_p1 !== (i < 4) || gnt_p0 !== (i == 8)) begin errors++;
        $display("[TB] FAIL lock_gnt[%0d]: got %b%b", i, gnt_p1, gnt_p0); end
      if (i >= 4 && i <= 7) begin
        checks++; if (ram_ce !== 1'b0) begin errors++;
          $display("[TB] FAIL lock_idle_ce[%0d]: got %b expected 0", i, ram_ce); end
      end
      checks++; if (rvalid_p0 !== m_rvalid[0] || rvalid_p1 !== m_rvalid[1] || rdata_p1 !== m_rdata[1]) begin errors++;
        $display("[TB] FAIL lock_ret[%0d]: got v=%b%b d1=%h expected v=%b%b d1=%h", i, rvalid_p1, rvalid_p0, rdata_p1, m_rvalid[1], m_rvalid[0], m_rdata[1]); end
      tick();
    end
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_boundary();
    logic [15:0] x, y;
    x = 16'($urandom); y = 16'($urandom);
    req_p1 = 1; we_p1 = 1; addr_p1 = 10'h3FF; wdata_p1 = x; #1;
    checks++; if (ram_ad !== 10'h3FF || ram_din !== x || ram_wre !== 1'b1) begin errors++;
      $display("[TB] FAIL bnd_wr_hi: got ad=%h din=%h wre=%b expected 3ff %h 1", ram_ad, ram_din, ram_wre, x); end
    tick();
    we_p1 = 0; tick();
    idle_inputs();
    req_p0 = 1; we_p0 = 1; addr_p0 = 10'h000; wdata_p0 = y; #1;
    checks++; if (rvalid_p1 !== 1'b0 || gnt_p0 !== 1'b1 || ram_ad !== 10'h000) begin errors++;
      $display("[TB] FAIL bnd_wr_lo: got v1=%b gnt0=%b ad=%h expected 0 1 000", rvalid_p1, gnt_p0, ram_ad); end
    tick();
    we_p0 = 0; #1;
    checks++; if (rvalid_p1 !== 1'b1 || rdata_p1 !== x) begin errors++;
      $display("[TB] FAIL bnd_rd_hi: got v1=%b d1=%h expected 1 %h", rvalid_p1, rdata_p1, x); end
    tick();
    idle_inputs(); tick();
    checks++; if (rvalid_p0 !== 1'b1 || rdata_p0 !== y) begin errors++;
      $display("[TB] FAIL bnd_rd_lo: got v0=%b d0=%h expected 1 %h", rvalid_p0, rdata_p0, y); end
    tick();
  endtask

  task automatic test_reset_inflight();
    req_p1 = 1; we_p1 = 0; addr_p1 = 10'($urandom); #1;
    checks++; if (gnt_p1 !== 1'b1) begin errors++;
      $display("[TB] FAIL inflight_gnt: got %b expected 1", gnt_p1); end
    tick();
    idle_inputs();
    #2 rst_n = 0;
    model_reset();
    @(posedge clk); #1;
    checks++; if (rvalid_p0 !== 1'b0 || rvalid_p1 !== 1'b0 || rdata_p0 !== 16'h0 || rdata_p1 !== 16'h0) begin errors++;
      $display("[TB] FAIL inflight_in_reset: got v=%b%b d=%h/%h expected 00 0000/0000", rvalid_p1, rvalid_p0, rdata_p0, rdata_p1); end
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rvalid_p0 !== 1'b0 || rvalid_p1 !== 1'b0 || rdata_p0 !== 16'h0 || rdata_p1 !== 16'h0) begin errors++;
        $display("[TB] FAIL inflight_after[%0d]: got v=%b%b d=%h/%h expected 00 0000/0000", i, rvalid_p1, rvalid_p0, rdata_p0, rdata_p1); end
    end
    req_p0 = 1; req_p1 = 1; #1;
    checks++; if (gnt_p0 !== 1'b1 || gnt_p1 !== 1'b0) begin errors++;
      $display("[TB] FAIL inflight_rr0: got %b%b expected p0 granted", gnt_p1, gnt_p0); end
    tick();
    idle_inputs(); tick(); tick();
  endtask

  task automatic test_random();
    int g;
    for (int i = 0; i < 300; i++) begin
      req_p0 = ($urandom_range(3) != 0); req_p1 = ($urandom_range(3) != 0);
      we_p0 = 1'($urandom); we_p1 = 1'($urandom);
      lock_p0 = ($urandom_range(3) == 0); lock_p1 = ($urandom_range(3) == 0);
      addr_p0 = 10'($urandom_range(15)); addr_p1 = 10'($urandom_range(15));
      wdata_p0 = 16'($urandom); wdata_p1 = 16'($urandom);
      #1;
      g = exp_grant();
      checks++; if (gnt_p0 !== (g == 0) || gnt_p1 !== (g == 1) || ram_ce !== (g >= 0)) begin errors++;
        $display("[TB] FAIL rnd_gnt[%0d]: got gnt=%b%b ce=%b expected port %0d", i, gnt_p1, gnt_p0, ram_ce, g); end
      if (g >= 0) begin
        checks++; if (ram_ad !== ((g == 1) ? addr_p1 : addr_p0) || ram_wre !== ((g == 1) ? we_p1 : we_p0)
                      || ram_din !== ((g == 1) ? wdata_p1 : wdata_p0)) begin errors++;
          $display("[TB] FAIL rnd_ram[%0d]: got ad=%h wre=%b din=%h for port %0d", i, ram_ad, ram_wre, ram_din, g); end
      end else begin
        checks++; if (ram_wre !== 1'b0) begin errors++;
          $display("[TB] FAIL rnd_idle_wre[%0d]: got %b expected 0", i, ram_wre); end
      end
      checks++; if (rvalid_p0 !== m_rvalid[0] || rvalid_p1 !== m_rvalid[1]
                    || rdata_p0 !== m_rdata[0] || rdata_p1 !== m_rdata[1]) begin errors++;
        $display("[TB] FAIL rnd_ret[%0d]: got v=%b%b d=%h/%h expected v=%b%b d=%h/%h", i, rvalid_p1, rvalid_p0,
                 rdata_p0, rdata_p1, m_rvalid[1], m_rvalid[0], m_rdata[0], m_rdata[1]); end
      tick();
    end
    idle_inputs();
    tick(); tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 0;
    idle_inputs();
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = 16'(i * 37) ^ 16'h5A00;
      m_mem[i]   = 16'(i * 37) ^ 16'h5A00;
    end
    ram_dout = '0;
    model_reset();
    test_reset();
    test_write_read();
    test_alternating();
    test_lock();
    test_boundary();
    test_reset_inflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
